tdc_event_frame_parser: RTL and testbench

- Receiving end of the 64-bit TDC event frame stream produced by the event builder, i.e. header, edge payload words and trailer.
- Validates frame structure, latches header fields, and emits one decoded edge per payload word through a backpressured output register.
- Ends each event with a one-cycle status pulse.
- Sits between the frame FIFO and the histogram/monitor logic on the readout board.

---
 rtl/tdc_frame_pkg.sv | 51 +++++
 rtl/tdc_edge_out_reg.sv | 29 ++
 rtl/tdc_event_frame_parser.sv | 202 ++++++++++++++++++++
 tb/tb_tdc_event_frame_parser.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_frame_pkg.sv
// rtl/tdc_frame_pkg.sv - shared TDC frame word layout, state encoding and status bit indices
package tdc_frame_pkg;

    localparam logic [3:0] TYPE_HDR   = 4'hA;
    localparam logic [3:0] TYPE_LEAD  = 4'h4;
    localparam logic [3:0] TYPE_TRAIL = 4'h5;
    localparam logic [3:0] TYPE_ERR   = 4'h6;
    localparam logic [3:0] TYPE_TRL   = 4'hC;

    localparam int TYPE_MSB      = 63;
    localparam int TYPE_LSB      = 60;
    localparam int HDR_TRIG_MSB  = 59;
    localparam int HDR_TRIG_LSB  = 56;
    localparam int HDR_LV1_MSB   = 55;
    localparam int HDR_LV1_LSB   = 32;
    localparam int HDR_BX_MSB    = 31;
    localparam int HDR_BX_LSB    = 20;
    localparam int HDR_FEC_MSB   = 19;
    localparam int HDR_FEC_LSB   = 8;
    localparam int HDR_FOV_MSB   = 7;
    localparam int HDR_FOV_LSB   = 4;
    localparam int HDR_H_BIT     = 3;
    localparam int HDR_D_MSB     = 1;
    localparam int HDR_D_LSB     = 0;
    localparam int EDGE_CH_MSB   = 59;
    localparam int EDGE_CH_LSB   = 53;
    localparam int EDGE_T_MSB    = 50;
    localparam int EDGE_T_LSB    = 32;
    localparam int ERR_FLAGS_MSB = 46;
    localparam int ERR_FLAGS_LSB = 32;
    localparam int TRL_LV1_MSB   = 55;
    localparam int TRL_LV1_LSB   = 32;
    localparam int TRL_CNT_MSB   = 19;
    localparam int TRL_CNT_LSB   = 8;

    localparam int EDGE_W = 27;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CLOSE   = 2'd2
    } state_t;

    localparam int STAT_TDC_ERR  = 0;
    localparam int STAT_LV1_MM   = 1;
    localparam int STAT_CNT_MM   = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_TRUNC    = 4;
    localparam int STAT_TIMEOUT  = 5;

endpackage

// File: rtl/tdc_edge_out_reg.sv
// rtl/tdc_edge_out_reg.sv - one-deep valid/ready holding register for decoded edges
module tdc_edge_out_reg #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         load_ok,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign load_ok = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tdc_event_frame_parser.sv
// rtl/tdc_event_frame_parser.sv - validates TDC event frames, forwards edges, reports per-event status
module tdc_event_frame_parser
    import tdc_frame_pkg::*;
#(
    parameter int MAX_EDGES      = 128,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       hdr_trigger_type,
    output logic [23:0]      hdr_lv1,
    output logic [11:0]      hdr_bx,
    output logic [11:0]      hdr_fec_id,
    output logic [3:0]       hdr_fov,
    output logic             hdr_h,
    output logic [1:0]       hdr_d,
    output logic [6:0]       edge_channel,
    output logic [18:0]      edge_time,
    output logic             edge_trailing,
    output logic             edge_valid,
    input  logic             edge_ready,
    output logic             event_done,
    output logic [5:0]       event_status,
    output logic [14:0]      event_error_flags,
    output logic [11:0]      event_word_count,
    output logic [CNT_W-1:0] dropped_words,
    output logic [CNT_W-1:0] event_count
);

    localparam int FWD_W = $clog2(MAX_EDGES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FWD_W-1:0] FWD_MAX  = FWD_W'(MAX_EDGES);
    localparam logic [FWD_W-1:0] FWD_ONE  = FWD_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    logic               pending_hdr;
    logic [11:0]        word_count;
    logic [FWD_W-1:0]   fwd_count;
    logic               overflow_q;
    logic               tdc_err_q;
    logic [14:0]        err_flags;
    logic [TMR_W-1:0]   timer;

    logic [3:0]         w_type;
    logic               is_hdr, is_edge, is_err, is_trl;
    logic               accept, in_payload, timeout_hit, close_now;
    logic               edge_load, edge_load_ok;
    logic [EDGE_W-1:0]  edge_bits;
    logic [11:0]        wc_inc;
    logic [5:0]         close_status;
    logic               unused_bits;

    assign unused_bits = in_data[2];

    assign w_type  = in_data[TYPE_MSB:TYPE_LSB];
    assign is_hdr  = (w_type == TYPE_HDR);
    assign is_edge = (w_type == TYPE_LEAD) || (w_type == TYPE_TRAIL);
    assign is_err  = (w_type == TYPE_ERR);
    assign is_trl  = (w_type == TYPE_TRL);

    assign in_ready    = (state != ST_CLOSE) && edge_load_ok;
    assign accept      = in_valid && in_ready;
    assign in_payload  = (state == ST_PAYLOAD);
    // An accepted word always beats a timer expiry in the same cycle.
    assign timeout_hit = in_payload && !accept && (timer == TMR_LAST);
    assign close_now   = in_payload && ((accept && (is_trl || is_hdr)) || timeout_hit);
    assign edge_load   = accept && in_payload && is_edge && (fwd_count < FWD_MAX);
    assign wc_inc      = (word_count == 12'hFFF) ? word_count : word_count + 12'd1;

    always_comb begin
        close_status                = '0;
        close_status[STAT_TDC_ERR]  = tdc_err_q;
        close_status[STAT_OVERFLOW] = overflow_q;
        close_status[STAT_LV1_MM]   = accept && is_trl
                                      && (in_data[TRL_LV1_MSB:TRL_LV1_LSB] != hdr_lv1);
        close_status[STAT_CNT_MM]   = accept && is_trl
                                      && (in_data[TRL_CNT_MSB:TRL_CNT_LSB] != word_count);
        close_status[STAT_TRUNC]    = accept && is_hdr;
        close_status[STAT_TIMEOUT]  = timeout_hit;
    end

    tdc_edge_out_reg #(.W(EDGE_W)) u_edge_out (
        .clk       (clk),
        .rst       (rst),
        .load      (edge_load),
        .load_data ({(w_type == TYPE_TRAIL),
                     in_data[EDGE_CH_MSB:EDGE_CH_LSB],
                     in_data[EDGE_T_MSB:EDGE_T_LSB]}),
        .load_ok   (edge_load_ok),
        .out_data  (edge_bits),
        .out_valid (edge_valid),
        .out_ready (edge_ready)
    );

    assign {edge_trailing, edge_channel, edge_time} = edge_bits;

    // A header is latched whether it opens an event from IDLE or truncates the open one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_trigger_type <= '0;
            hdr_lv1          <= '0;
            hdr_bx           <= '0;
            hdr_fec_id       <= '0;
            hdr_fov          <= '0;
            hdr_h            <= 1'b0;
            hdr_d            <= '0;
        end else if (accept && is_hdr) begin
            hdr_trigger_type <= in_data[HDR_TRIG_MSB:HDR_TRIG_LSB];
            hdr_lv1          <= in_data[HDR_LV1_MSB:HDR_LV1_LSB];
            hdr_bx           <= in_data[HDR_BX_MSB:HDR_BX_LSB];
            hdr_fec_id       <= in_data[HDR_FEC_MSB:HDR_FEC_LSB];
            hdr_fov          <= in_data[HDR_FOV_MSB:HDR_FOV_LSB];
            hdr_h            <= in_data[HDR_H_BIT];
            hdr_d            <= in_data[HDR_D_MSB:HDR_D_LSB];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            pending_hdr       <= 1'b0;
            word_count        <= '0;
            fwd_count         <= '0;
            overflow_q        <= 1'b0;
            tdc_err_q         <= 1'b0;
            err_flags         <= '0;
            timer             <= '0;
            event_done        <= 1'b0;
            event_status      <= '0;
            event_error_flags <= '0;
            event_word_count  <= '0;
            dropped_words     <= '0;
            event_count       <= '0;
        end else begin
            event_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_hdr) begin
                            state <= ST_PAYLOAD;
                        end else if (dropped_words != '1) begin
                            dropped_words <= dropped_words + CNT_ONE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        timer <= '0;
                    end else if (!timeout_hit) begin
                        timer <= timer + TMR_ONE;
                    end
                    if (accept) begin
                        if (is_edge) begin
                            word_count <= wc_inc;
                            if (fwd_count < FWD_MAX) begin
                                fwd_count <= fwd_count + FWD_ONE;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else if (is_err) begin
                            word_count <= wc_inc;
                            err_flags  <= err_flags | in_data[ERR_FLAGS_MSB:ERR_FLAGS_LSB];
                            tdc_err_q  <= 1'b1;
                        end else if (is_hdr) begin
                            pending_hdr <= 1'b1;
                        end else if (!is_trl) begin
                            word_count <= wc_inc;
                            tdc_err_q  <= 1'b1;
                        end
                    end
                    if (close_now) begin
                        state             <= ST_CLOSE;
                        event_done        <= 1'b1;
                        event_status      <= close_status;
                        event_error_flags <= err_flags;
                        event_word_count  <= word_count;
                    end
                end
                ST_CLOSE: begin
                    event_count <= event_count + CNT_ONE;
                    word_count  <= '0;
                    fwd_count   <= '0;
                    overflow_q  <= 1'b0;
                    tdc_err_q   <= 1'b0;
                    err_flags   <= '0;
                    timer       <= '0;
                    pending_hdr <= 1'b0;
                    state       <= pending_hdr ? ST_PAYLOAD : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_event_frame_parser.sv
// tb/tb_tdc_event_frame_parser.sv - scoreboard bench for tdc_event_frame_parser
module tb_tdc_event_frame_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  hdr_trigger_type;
    logic [23:0] hdr_lv1;
    logic [11:0] hdr_bx;
    logic [11:0] hdr_fec_id;
    logic [3:0]  hdr_fov;
    logic        hdr_h;
    logic [1:0]  hdr_d;
    logic [6:0]  edge_channel;
    logic [18:0] edge_time;
    logic        edge_trailing;
    logic        edge_valid;
    logic        edge_ready = 1'b1;
    logic        event_done;
    logic [5:0]  event_status;
    logic [14:0] event_error_flags;
    logic [11:0] event_word_count;
    logic [15:0] dropped_words;
    logic [15:0] event_count;

    typedef struct packed {
        logic [5:0]  st;
        logic [14:0] fl;
        logic [11:0] wc;
    } ev_t;

    logic [26:0] exp_edge[$];
    ev_t         exp_ev[$];
    int          total = 0;
    int          passed = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    tdc_event_frame_parser #(.MAX_EDGES(128), .TIMEOUT_CYCLES(1024), .CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .hdr_trigger_type  (hdr_trigger_type),
        .hdr_lv1           (hdr_lv1),
        .hdr_bx            (hdr_bx),
        .hdr_fec_id        (hdr_fec_id),
        .hdr_fov           (hdr_fov),
        .hdr_h             (hdr_h),
        .hdr_d             (hdr_d),
        .edge_channel      (edge_channel),
        .edge_time         (edge_time),
        .edge_trailing     (edge_trailing),
        .edge_valid        (edge_valid),
        .edge_ready        (edge_ready),
        .event_done        (event_done),
        .event_status      (event_status),
        .event_error_flags (event_error_flags),
        .event_word_count  (event_word_count),
        .dropped_words     (dropped_words),
        .event_count       (event_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] hdr_w(input logic [3:0] trig, input logic [23:0] lv1,
                                          input logic [11:0] bx, input logic [11:0] fec,
                                          input logic [3:0] fov, input logic h, input logic [1:0] d);
        return {4'hA, trig, lv1, bx, fec, fov, h, 1'b0, d};
    endfunction

    function automatic logic [63:0] edge_w(input logic trail, input logic [6:0] ch, input logic [18:0] t);
        return {(trail ? 4'h5 : 4'h4), ch, 2'b11, t, 32'hDEADBEEF};
    endfunction

    function automatic logic [63:0] err_w(input logic [14:0] fl);
        return {4'h6, 13'h0, fl, 32'h0};
    endfunction

    function automatic logic [63:0] trl_w(input logic [23:0] lv1, input logic [11:0] cnt);
        return {4'hC, 4'h0, lv1, 12'h0, cnt, 8'h0};
    endfunction

    task automatic send(input logic [63:0] w);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                total++;
                $display("FAIL send_timeout: in_ready stuck low for word %0h", w);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_edge(input logic trail, input logic [6:0] ch, input logic [18:0] t, input logic fwd);
        if (fwd) exp_edge.push_back({trail, ch, t});
        send(edge_w(trail, ch, t));
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over an edge or closes an event.
    initial begin
        logic [26:0] e;
        ev_t         v;
        forever begin
            @(negedge clk);
            if (edge_valid && edge_ready) begin
                if (exp_edge.size() == 0) begin
                    total++;
                    $display("FAIL edge_unexpected: got %0h with empty queue", {edge_trailing, edge_channel, edge_time});
                end else begin
                    e = exp_edge.pop_front();
                    chk("edge", {edge_trailing, edge_channel, edge_time}, e);
                end
            end
            if (event_done) begin
                done_cnt++;
                chk("close_in_ready", in_ready, 0);
                if (exp_ev.size() == 0) begin
                    total++;
                    $display("FAIL event_unexpected: status %0h with empty queue", event_status);
                end else begin
                    v = exp_ev.pop_front();
                    chk("ev_status", event_status, v.st);
                    chk("ev_flags", event_error_flags, v.fl);
                    chk("ev_word_count", event_word_count, v.wc);
                end
            end
        end
    end

    initial begin
        int n;
        #1;
        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_edge_valid", edge_valid, 0);
        chk("rst_event_done", event_done, 0);
        chk("rst_hdr_lv1", hdr_lv1, 0);
        chk("rst_counts", {dropped_words, event_count}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. clean event
        send(hdr_w(4'h3, 24'h000123, 12'h01E, 12'h00A, 4'h2, 1'b1, 2'b01));
        send_edge(1'b0, 7'd5, 19'd100, 1'b1);
        send_edge(1'b1, 7'd5, 19'd180, 1'b1);
        send_edge(1'b0, 7'd9, 19'd7, 1'b1);
        exp_ev.push_back('{st: 6'b000000, fl: 15'h0, wc: 12'd3});
        send(trl_w(24'h000123, 12'd3));
        settle();
        chk("t1_hdr", {hdr_trigger_type, hdr_lv1, hdr_bx, hdr_fec_id, hdr_fov, hdr_h, hdr_d},
            {4'h3, 24'h000123, 12'h01E, 12'h00A, 4'h2, 1'b1, 2'b01});
        chk("t1_event_count", event_count, 1);
        chk("t1_done_cnt", done_cnt, 1);

        // 2. backpressure
        fork
            begin
                send(hdr_w(4'h1, 24'h000200, 12'h002, 12'h003, 4'h0, 1'b0, 2'b00));
                send_edge(1'b0, 7'd3, 19'd1000, 1'b1);
                send_edge(1'b1, 7'd3, 19'd1050, 1'b1);
                send_edge(1'b0, 7'd4, 19'd2000, 1'b1);
                send_edge(1'b1, 7'd4, 19'd2100, 1'b1);
                exp_ev.push_back('{st: 6'b000000, fl: 15'h0, wc: 12'd4});
                send(trl_w(24'h000200, 12'd4));
            end
            begin
                n = 0;
                while (!edge_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("t2_edge_seen", edge_valid, 1);
                edge_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t2_in_ready_low", in_ready, 0);
                    chk("t2_edge_stable", {edge_valid, edge_trailing, edge_channel, edge_time},
                        {1'b1, 1'b0, 7'd3, 19'd1000});
                end
                @(posedge clk);
                #1;
                edge_ready = 1'b1;
            end
        join
        settle();
        chk("t2_event_count", event_count, 2);
        chk("t2_edges_drained", exp_edge.size(), 0);

        // 3. lv1 and count mismatch
        send(hdr_w(4'h0, 24'h000123, 12'h010, 12'h00A, 4'h0, 1'b0, 2'b00));
        send_edge(1'b0, 7'd1, 19'd11, 1'b1);
        send_edge(1'b0, 7'd2, 19'd22, 1'b1);
        send_edge(1'b1, 7'd1, 19'd33, 1'b1);
        exp_ev.push_back('{st: 6'b000110, fl: 15'h0, wc: 12'd3});
        send(trl_w(24'h000124, 12'd2));
        settle();

        // 4. overflow and error word
        send(hdr_w(4'h0, 24'h000300, 12'h020, 12'h00B, 4'h0, 1'b0, 2'b00));
        for (int i = 0; i < 130; i++) begin
            send_edge(i[0], 7'(i % 128), 19'(i * 3), (i < 128));
        end
        send(err_w(15'h0011));
        exp_ev.push_back('{st: 6'b001001, fl: 15'h0011, wc: 12'd131});
        send(trl_w(24'h000300, 12'd131));
        settle();
        chk("t4_event_count", event_count, 4);
        chk("t4_edges_drained", exp_edge.size(), 0);

        // 5. drops, truncation and resync
        do_reset();
        chk("t5_rst_counts", {dropped_words, event_count}, 0);
        send(edge_w(1'b0, 7'd8, 19'd5));
        send(trl_w(24'h000001, 12'd0));
        send(hdr_w(4'h0, 24'h000400, 12'h030, 12'h00C, 4'h0, 1'b0, 2'b00));
        send_edge(1'b0, 7'd6, 19'd60, 1'b1);
        exp_ev.push_back('{st: 6'b010000, fl: 15'h0, wc: 12'd1});
        send(hdr_w(4'h5, 24'h000401, 12'h031, 12'h00D, 4'h0, 1'b0, 2'b10));
        send_edge(1'b0, 7'd7, 19'd70, 1'b1);
        send_edge(1'b1, 7'd7, 19'd75, 1'b1);
        exp_ev.push_back('{st: 6'b000000, fl: 15'h0, wc: 12'd2});
        send(trl_w(24'h000401, 12'd2));
        settle();
        chk("t5_dropped", dropped_words, 2);
        chk("t5_event_count", event_count, 2);
        chk("t5_hdr_lv1", hdr_lv1, 24'h000401);
        chk("t5_hdr_d", hdr_d, 2'b10);

        // 6. timeout, then reset mid-event
        send(hdr_w(4'h0, 24'h000055, 12'h040, 12'h00E, 4'h0, 1'b0, 2'b00));
        exp_ev.push_back('{st: 6'b100000, fl: 15'h0, wc: 12'd0});
        n = 0;
        while (n < 1200) begin
            @(negedge clk);
            n++;
            if (event_done) break;
        end
        chk("t6_timeout_latency", (n >= 1024 && n <= 1026), 1);
        settle();
        chk("t6_event_count", event_count, 3);
        send(hdr_w(4'h2, 24'h000066, 12'h041, 12'h00F, 4'h1, 1'b1, 2'b11));
        send(edge_w(1'b0, 7'd9, 19'd99));
        n = done_cnt;
        rst = 1'b1;
        #1;
        chk("t6_rst_edge_valid", edge_valid, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_hdr", {hdr_trigger_type, hdr_lv1, hdr_bx, hdr_fec_id, hdr_fov, hdr_h, hdr_d}, 0);
        chk("t6_rst_event", {event_done, event_status, event_error_flags, event_word_count}, 0);
        chk("t6_rst_counts", {dropped_words, event_count}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(edge_w(1'b1, 7'd1, 19'd1));
        settle();
        chk("t6_no_done_after_rst", done_cnt, n);
        chk("t6_idle_drop", dropped_words, 1);

        chk("final_done_cnt", done_cnt, 7);
        chk("final_edge_q", exp_edge.size(), 0);
        chk("final_ev_q", exp_ev.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
